des_sbox_loader: RTL and testbench

Run-time programming controller for the DES S-box tables. It accepts a stream of 4-bit table entries over a valid/ready handshake and sequences them into the S-box edit port (`edit_sbox`, `sbox_sel`, `row_sel`, `col_sel`, `new_sbox_val`) shared by all eight S-box instances. It sits directly upstream of the S-boxes on the configuration side. It asserts `cipher_hold` so the round datapath stalls while tables are inconsistent.

---
 rtl/des_sbox_loader_if.sv | 24 ++
 rtl/des_sbox_loader.sv | 115 +++++++++++
 tb/tb_des_sbox_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_loader_if.sv
// Stream-in / S-box edit-out bundle for the S-box table loader.
// slave = loader view, master = stream source and S-box edit consumer view.
interface des_sbox_loader_if #(
    parameter int SEL_W = 3
);
    logic             s_valid;
    logic [3:0]       s_data;
    logic             s_ready;
    logic             edit_sbox;
    logic [SEL_W-1:0] sbox_sel;
    logic [1:0]       row_sel;
    logic [3:0]       col_sel;
    logic [3:0]       new_sbox_val;

    modport slave (
        input  s_valid, s_data,
        output s_ready, edit_sbox, sbox_sel, row_sel, col_sel, new_sbox_val
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, edit_sbox, sbox_sel, row_sel, col_sel, new_sbox_val
    );
endinterface

// File: rtl/des_sbox_loader.sv
// Sequences a 4-bit entry stream into the shared S-box edit port, one write per accepted beat.
// Latency: beat accepted in N is written in N+1; s_ready is high for the whole LOAD state.
module des_sbox_loader #(
    parameter  int NUM_SBOX = 8,
    localparam int SEL_W    = $clog2(NUM_SBOX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cfg_start,
    input  logic             i_cfg_all,
    input  logic [SEL_W-1:0] i_cfg_sbox,
    input  logic             i_cfg_abort,
    des_sbox_loader_if.slave s_if,
    output logic             o_busy,
    output logic             o_cipher_hold,
    output logic             o_done,
    output logic             o_aborted
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [SEL_W-1:0] r_sbox;
    logic [SEL_W-1:0] r_end;
    logic [1:0]       r_row;
    logic [3:0]       r_col;
    logic             r_edit;
    logic [SEL_W-1:0] r_sbox_sel;
    logic [1:0]       r_row_sel;
    logic [3:0]       r_col_sel;
    logic [3:0]       r_val;
    logic             r_done;
    logic             r_aborted;
    logic             w_s_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == LOAD) && s_if.s_valid;
    assign w_last   = w_accept && (r_col == 4'd15) && (r_row == 2'd3) && (r_sbox == r_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Abort takes priority over completing on the last beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_cfg_start) w_next = LOAD;
            LOAD:    if (i_cfg_abort) w_next = IDLE;
                     else if (w_last) w_next = DRAIN;
            DRAIN:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_s_ready = (r_state == LOAD);
        w_busy    = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sbox <= '0;
            r_end  <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (r_state == IDLE && i_cfg_start) begin
            r_sbox <= i_cfg_all ? '0 : i_cfg_sbox;
            r_end  <= i_cfg_all ? SEL_W'(NUM_SBOX - 1) : i_cfg_sbox;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_accept) begin
            // Column fastest, then row, then S-box.
            r_col <= r_col + 4'd1;
            if (r_col == 4'd15)                  r_row  <= r_row + 2'd1;
            if (r_col == 4'd15 && r_row == 2'd3) r_sbox <= r_sbox + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edit     <= 1'b0;
            r_sbox_sel <= '0;
            r_row_sel  <= '0;
            r_col_sel  <= '0;
            r_val      <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_edit    <= w_accept;
            r_done    <= (r_state == DRAIN);
            r_aborted <= (r_state == LOAD) && i_cfg_abort;
            if (w_accept) begin
                r_sbox_sel <= r_sbox;
                r_row_sel  <= r_row;
                r_col_sel  <= r_col;
                r_val      <= s_if.s_data;
            end
        end
    end

    assign s_if.s_ready      = w_s_ready;
    assign s_if.edit_sbox    = r_edit;
    assign s_if.sbox_sel     = r_sbox_sel;
    assign s_if.row_sel      = r_row_sel;
    assign s_if.col_sel      = r_col_sel;
    assign s_if.new_sbox_val = r_val;
    assign o_busy            = w_busy;
    assign o_cipher_hold     = w_busy;
    assign o_done            = r_done;
    assign o_aborted         = r_aborted;
endmodule

// File: tb/tb_des_sbox_loader.sv
// Directed load scenarios with random data/valid patterns, checked against an address-order model
// and a behavioural S-box memory written from the edit port.
module tb_des_sbox_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_cfg_start = 1'b0;
    logic       i_cfg_all = 1'b0;
    logic [2:0] i_cfg_sbox = 3'd0;
    logic       i_cfg_abort = 1'b0;
    logic       o_busy, o_cipher_hold, o_done, o_aborted;

    des_sbox_loader_if #(.SEL_W(3)) ifc ();

    des_sbox_loader #(.NUM_SBOX(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cfg_start   (i_cfg_start),
        .i_cfg_all     (i_cfg_all),
        .i_cfg_sbox    (i_cfg_sbox),
        .i_cfg_abort   (i_cfg_abort),
        .s_if          (ifc.slave),
        .o_busy        (o_busy),
        .o_cipher_hold (o_cipher_hold),
        .o_done        (o_done),
        .o_aborted     (o_aborted)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          n_abort = 0;
    logic [3:0]  mem [512];
    logic [12:0] wq [$];
    logic [3:0]  vals [512];
    int          s1 [64] = '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
                              0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
                              4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
                             15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13};

    // Behavioural S-box storage plus write/pulse capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && ifc.edit_sbox === 1'b1) begin
            wq.push_back({ifc.sbox_sel, ifc.row_sel, ifc.col_sel, ifc.new_sbox_val});
            mem[{ifc.sbox_sel, ifc.row_sel, ifc.col_sel}] = ifc.new_sbox_val;
        end
        if (o_done === 1'b1)    n_done++;
        if (o_aborted === 1'b1) n_abort++;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 512; i++) mem[i] = 4'd0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. dmode: 0 S1 table, 1 all 0xA, 2 random.
    task automatic run_load(input string tag, input bit all, input logic [2:0] sel,
                            input int vmode, input int dmode, input int abort_at,
                            input int start_at, input int rst_at);
        int n, k, cyc, base, exp_w, bad;
        bit v, ab, rs, busy_drop, started;
        logic [12:0] e;
        n = all ? 512 : 64;
        base = all ? 0 : int'(sel);
        for (int i = 0; i < n; i++)
            vals[i] = (dmode == 0) ? 4'(s1[i % 64]) : (dmode == 1) ? 4'hA : 4'($urandom_range(0, 15));
        wq.delete();
        n_done = 0;
        n_abort = 0;
        i_cfg_start = 1'b1; i_cfg_all = all; i_cfg_sbox = sel;
        tick();
        i_cfg_start = 1'b0; i_cfg_all = ~all; i_cfg_sbox = 3'($urandom);
        chk({tag, ".busy_after_start"}, 32'(o_busy), 32'd1);
        chk({tag, ".ready_after_start"}, 32'(ifc.s_ready), 32'd1);
        k = 0; cyc = 0; ab = 0; rs = 0; busy_drop = 0; started = 0;
        while (k < n && !ab && !rs && cyc < 4000) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            ifc.s_valid = v;
            ifc.s_data  = vals[k];
            if (v && k == abort_at) begin i_cfg_abort = 1'b1; ab = 1; end
            if (k == start_at && !started) begin i_cfg_start = 1'b1; i_cfg_sbox = 3'd3; started = 1; end
            tick();
            if (v) k++;
            if (o_busy !== 1'b1 && !ab) busy_drop = 1;
            ifc.s_valid = 1'b0; i_cfg_abort = 1'b0; i_cfg_start = 1'b0;
            cyc++;
            if (k == rst_at) rs = 1;
        end
        if (rs) begin
            rst_n = 1'b0;
            #1;
            chk({tag, ".outs_in_reset"},
                {12'd0, o_busy, o_cipher_hold, o_done, o_aborted, ifc.s_ready, ifc.edit_sbox,
                 ifc.sbox_sel, ifc.row_sel, ifc.col_sel, ifc.new_sbox_val}, 32'd0);
            chk({tag, ".sbox_mem_reset"}, 32'(mem[{sel, 6'd0}]), 32'd0);
            #2;
            rst_n = 1'b1;
            return;
        end
        chk({tag, ".cycle_budget"}, 32'(k < n && !ab), 32'd0);
        if (ab) begin
            chk({tag, ".aborted_pulse"}, 32'(o_aborted), 32'd1);
            chk({tag, ".idle_after_abort"}, {30'd0, o_busy, ifc.s_ready}, 32'd0);
            chk({tag, ".write_with_abort"}, 32'(ifc.edit_sbox), 32'd1);
            tick();
            chk({tag, ".aborted_one_cycle"}, 32'(o_aborted), 32'd0);
            exp_w = abort_at + 1;
        end else begin
            chk({tag, ".drain_busy"}, {30'd0, o_busy, o_done}, 32'd2);
            chk({tag, ".drain_last_write"}, 32'(ifc.edit_sbox), 32'd1);
            tick();
            chk({tag, ".done_pulse"}, {30'd0, o_done, o_busy}, 32'd2);
            tick();
            chk({tag, ".done_one_cycle"}, 32'(o_done), 32'd0);
            chk({tag, ".busy_throughout"}, 32'(busy_drop), 32'd0);
            exp_w = n;
        end
        chk({tag, ".write_count"}, 32'(wq.size()), 32'(exp_w));
        bad = 0;
        for (int i = 0; i < wq.size() && i < exp_w; i++) begin
            e = {3'(base + i / 64), 2'((i / 16) % 4), 4'(i % 16), vals[i]};
            if (wq[i] !== e) bad++;
        end
        chk({tag, ".write_sequence"}, 32'(bad), 32'd0);
        chk({tag, ".done_count"}, 32'(n_done), ab ? 32'd0 : 32'd1);
        chk({tag, ".abort_count"}, 32'(n_abort), ab ? 32'd1 : 32'd0);
    endtask

    initial begin
        ifc.s_valid = 1'b0;
        ifc.s_data  = 4'd0;
        #12;
        chk("reset.outs",
            {12'd0, o_busy, o_cipher_hold, o_done, o_aborted, ifc.s_ready, ifc.edit_sbox,
             ifc.sbox_sel, ifc.row_sel, ifc.col_sel, ifc.new_sbox_val}, 32'd0);
        rst_n = 1'b1;
        tick();

        i_cfg_abort = 1'b1;
        tick();
        i_cfg_abort = 1'b0;
        chk("idle_abort.ignored", {30'd0, o_busy, o_aborted}, 32'd0);

        run_load("s1_load", 1'b0, 3'd0, 0, 0, -1, -1, -1);
        chk("s1_load.sbox1_in00", 32'(mem[0]), 32'd14);
        chk("s1_load.sbox1_in3f", 32'(mem[63]), 32'd13);

        run_load("full_bp", 1'b1, 3'd0, 1, 2, -1, -1, -1);
        chk("full_bp.last_sel", 32'(ifc.sbox_sel), 32'd7);

        run_load("sbox5_a", 1'b0, 3'd5, 0, 1, -1, -1, -1);
        chk("sbox5_a.sbox6_in21", 32'(mem[5 * 64 + 48]), 32'd10);

        run_load("abort20", 1'b0, 3'd4, 0, 2, 20, -1, -1);
        run_load("abort_last", 1'b0, 3'd7, 0, 2, 63, -1, -1);
        run_load("start_busy", 1'b0, 3'd2, 2, 2, -1, 10, -1);
        run_load("rst_mid", 1'b0, 3'd6, 0, 2, -1, -1, 30);

        ifc.s_valid = 1'b1;
        wq.delete();
        tick(); tick(); tick();
        ifc.s_valid = 1'b0;
        chk("rst_mid.no_writes_idle", 32'(wq.size()), 32'd0);

        run_load("fresh", 1'b0, 3'd6, 2, 2, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
